bit_field_unpacker: RTL and testbench
=====================================

# bit_field_unpacker

Streaming bit-field extractor that sits directly upstream of the combinational right-shift stage. It accepts WORD-bit packed words, keeps them in a 2*WORD-bit LSB-first bit buffer, and on each accepted request emits the next rlen bits as a zero-extended field. The buffer is then advanced by rlen bits, which is the shift amount driven into the right-shift stage. Used wherever variable-length packed fields (headers, entropy-coded symbols) are unpacked from a word stream.

## Interface
- LOGWORD, default 5: log2 of word width; must be >= 1.
- WORD, derived (localparam) as 1<<LOGWORD: word and maximum field width.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- iword  in  WORD  packed input word; iword[0] is the oldest bit.
- ivalid  in  1  iword is valid.
- iready  out  1  input word accepted when ivalid && iready.
- iflush  in  1  discard all buffered bits this cycle.
- rlen  in  LOGWORD+1  requested field length; legal range 0..WORD.
- rvalid  in  1  request valid.
- rready  out  1  request accepted when rvalid && rready.
- ofield  out  WORD  extracted field; bits at and above rlen are zero.
- ovalid  out  1  ofield valid.
- oready  in  1  ofield consumed when ovalid && oready.
- err  out  1  sticky: an illegal rlen (> WORD) was presented with rvalid.

## Operation
- State:
  - bitbuf[2*WORD-1:0], where bit 0 is the oldest bit.
  - cnt, LOGWORD+2 bits, range 0..2*WORD.
  - ofield/ovalid output register.
  - err.
- iready = (cnt <= WORD) && !iflush. Computed from registered cnt only.
- rready = (!ovalid || oready) && (rlen <= cnt) && (rlen <= WORD) && !iflush.
- Pop, on a request handshake:
  - ofield <= bitbuf[WORD-1:0] with bits >= rlen forced to 0.
  - ovalid <= 1.
  - bitbuf <= bitbuf >> rlen, with zero fill.
  - cnt <= cnt - rlen.
- rlen = 0 is legal: produces ofield = 0 with ovalid = 1 and consumes nothing.
- Push, on an input handshake: iword is written into bitbuf at bit position cnt, and cnt increases by WORD.
- Simultaneous push and pop:
  - iword is placed at bit position (cnt - rlen) in the shifted buffer.
  - cnt <= cnt - rlen + WORD.
  - The shift is applied before the insert.
- Output register behaviour:
  - If ovalid && oready and there is no new pop, ovalid <= 0.
  - ofield holds its value while ovalid && !oready.
- Illegal rlen: rvalid with rlen > WORD sets err <= 1. The request is never accepted. err clears only on reset.
- Starvation: when rlen > cnt, the request waits with rready = 0. No partial field is ever emitted.
- iflush:
  - cnt <= 0 and bitbuf <= 0.
  - Any push or pop in the same cycle is suppressed.
  - A pending ovalid/ofield is unaffected.
- Bits in bitbuf at positions >= cnt are always zero.

## Timing
- Reset (reset_n low at an edge) forces:
  - cnt = 0, bitbuf = 0.
  - ofield = 0, ovalid = 0, err = 0.
  - Therefore iready = 1 and rready = 0 on the first cycle after reset.
- Reset takes priority over every other input, including mid-transfer. Any in-flight field is dropped.
- Request-to-field latency is 1 cycle: a request accepted at edge N gives ovalid = 1 and a valid ofield after edge N.
- A word pushed at edge N is extractable by a request at edge N+1. There is no same-cycle bypass.
- Throughput is one field per cycle with oready held high, as long as the buffer holds rlen bits.
- rready depends combinationally on rlen, rvalid-independent inputs and registered state. iready depends on registered state and iflush only.

## Test plan
All scenarios use LOGWORD = 3 (WORD = 8).
- Reset and basic extraction:
  - Stimulus: reset, push 0xA5, request rlen = 3, then request rlen = 5.
  - Required response: ofield = 0x05, then 0x14. Afterwards cnt = 0 and rready = 0 for any rlen > 0.
- Word-spanning field:
  - Stimulus: push 0xFF, push 0x00, request 4, then request 8.
  - Required response: ofield = 0x0F, then 0x0F. Remaining cnt = 4.
- Simultaneous push and pop:
  - Stimulus: with cnt = 8 holding 0xA5, push 0x3C in the same cycle as request 3. Then request 8.
  - Required response: ofield = 0x05 and cnt = 13, then ofield = 0x94 and cnt = 5.
- Backpressure:
  - Stimulus: ovalid = 1 with oready = 0 for 3 cycles, rvalid = 1.
  - Required response: rready = 0 throughout and ofield stable. With oready = 1 the next field follows on the next edge.
- Full buffer and illegal length:
  - Stimulus: push twice with no pops. Then present rlen = 9.
  - Required response: iready = 0 at cnt = 16. rlen = 9 is not accepted, err = 1 and stays 1 until reset.
- Flush and mid-operation reset:
  - Stimulus: iflush with cnt = 11. Separately, reset_n low while ovalid = 1.
  - Required response: after the flush, cnt = 0 with the pending output kept. After the reset, all outputs are at their reset values on the next cycle.

Source files
------------

// File: rtl/bit_field_unpacker.sv
// Streaming bit-field extractor: buffers packed words LSB-first and emits
// zero-extended fields of a requested length, one per accepted request.
module bit_field_unpacker #(
  parameter int LOGWORD = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [(1<<LOGWORD)-1:0]    iword,
  input  logic                       ivalid,
  output logic                       iready,
  input  logic                       iflush,
  input  logic [LOGWORD:0]           rlen,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [(1<<LOGWORD)-1:0]    ofield,
  output logic                       ovalid,
  input  logic                       oready,
  output logic                       err,
  output logic [LOGWORD+1:0]         dbg_cnt
);

  localparam int WORD = 1 << LOGWORD;
  localparam int BW   = 2 * WORD;
  localparam int CW   = LOGWORD + 2;
  localparam logic [CW-1:0] WORD_C = CW'(WORD);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready never depends on the matching valid, and a flush blocks both.

  logic [BW-1:0]   r_bitbuf;
  logic [CW-1:0]   r_cnt;
  logic [WORD-1:0] r_ofield;
  logic            r_ovalid;
  logic            r_err;

  logic [CW-1:0]   w_rlen;
  logic            w_rlen_legal;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_shamt;
  logic [CW-1:0]   w_base;
  logic [BW-1:0]   w_shifted;
  logic [BW-1:0]   w_insert;
  logic [WORD-1:0] w_mask;
  logic [WORD-1:0] w_field;
  logic [CW-1:0]   w_cnt_next;

  assign w_rlen       = {1'b0, rlen};
  assign w_rlen_legal = (w_rlen <= WORD_C);

  assign iready = (r_cnt <= WORD_C) && !iflush;
  assign rready = (!r_ovalid || oready) && (w_rlen <= r_cnt) && w_rlen_legal && !iflush;

  assign w_push = ivalid && iready;
  assign w_pop  = rvalid && rready;

  // Shift out the popped bits first, then drop the new word just above the
  // surviving bits; a push only happens with cnt <= WORD so it always fits.
  assign w_shamt    = w_pop ? w_rlen : '0;
  assign w_base     = r_cnt - w_shamt;
  assign w_shifted  = r_bitbuf >> w_shamt;
  assign w_insert   = w_push ? ({{WORD{1'b0}}, iword} << w_base) : '0;
  assign w_cnt_next = w_base + (w_push ? WORD_C : '0);

  // A shift by WORD clears every bit, so rlen == WORD yields an all-ones mask.
  assign w_mask  = ~({WORD{1'b1}} << rlen);
  assign w_field = r_bitbuf[WORD-1:0] & w_mask;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_bitbuf <= '0;
      r_cnt    <= '0;
      r_ofield <= '0;
      r_ovalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (iflush) begin
        r_bitbuf <= '0;
        r_cnt    <= '0;
      end else if (w_push || w_pop) begin
        r_bitbuf <= w_shifted | w_insert;
        r_cnt    <= w_cnt_next;
      end

      if (w_pop) begin
        r_ofield <= w_field;
        r_ovalid <= 1'b1;
      end else if (r_ovalid && oready) begin
        r_ovalid <= 1'b0;
      end

      if (rvalid && !w_rlen_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ofield  = r_ofield;
  assign ovalid  = r_ovalid;
  assign err     = r_err;
  assign dbg_cnt = r_cnt;

endmodule

// File: tb/tb_bit_field_unpacker.sv
// Bench for bit_field_unpacker (WORD = 8): directed vector table plus
// randomized traffic checked against a bit-queue reference model.
module tb_bit_field_unpacker;

  logic       clock;
  logic       reset_n;
  logic [7:0] iword;
  logic       ivalid;
  logic       iready;
  logic       iflush;
  logic [3:0] rlen;
  logic       rvalid;
  logic       rready;
  logic [7:0] ofield;
  logic       ovalid;
  logic       oready;
  logic       err;
  logic [4:0] dbg_cnt;

  bit_field_unpacker #(.LOGWORD(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .iword   (iword),
    .ivalid  (ivalid),
    .iready  (iready),
    .iflush  (iflush),
    .rlen    (rlen),
    .rvalid  (rvalid),
    .rready  (rready),
    .ofield  (ofield),
    .ovalid  (ovalid),
    .oready  (oready),
    .err     (err),
    .dbg_cnt (dbg_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: buffered bits as a FIFO of single bits, oldest first
  bit         m_bq[$];
  logic       m_ov  = 1'b0;
  logic [7:0] m_of  = 8'h00;
  logic       m_err = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // driver: one clock cycle, inputs applied after the falling edge
  task automatic step(input logic rst, input logic [7:0] w, input logic iv,
                      input logic fl, input logic [3:0] rl, input logic rv,
                      input logic orr, input logic pre_chk,
                      output logic s_ir, output logic s_rr);
    logic       m_ir, m_rr, push, pop;
    logic [7:0] f;
    int         sz;
    f = 8'h00;
    reset_n = !rst; iword = w; ivalid = iv; iflush = fl;
    rlen = rl; rvalid = rv; oready = orr;
    #1;
    s_ir = iready;
    s_rr = rready;
    sz   = m_bq.size();
    m_ir = (sz <= 8) && !fl;
    m_rr = (!m_ov || orr) && (int'(rl) <= sz) && (int'(rl) <= 8) && !fl;
    if (pre_chk && !rst) begin
      chk("iready", int'(iready), int'(m_ir));
      chk("rready", int'(rready), int'(m_rr));
    end
    if (!rst && m_ov && orr) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else chk("ofield_sb", int'(ofield), int'(exp_q.pop_front()));
    end
    @(posedge clock);
    if (rst) begin
      m_bq.delete(); exp_q.delete();
      m_ov = 1'b0; m_of = 8'h00; m_err = 1'b0;
    end else begin
      push = iv && m_ir;
      pop  = rv && m_rr;
      if (fl) m_bq.delete();
      else begin
        if (pop) for (int i = 0; i < int'(rl); i++) f[i] = m_bq.pop_front();
        if (push) for (int i = 0; i < 8; i++) m_bq.push_back(w[i]);
      end
      if (pop) begin
        m_ov = 1'b1; m_of = f; exp_q.push_back(f);
      end else if (m_ov && orr) m_ov = 1'b0;
      if (rv && int'(rl) > 8) m_err = 1'b1;
    end
    #1;
    chk("ovalid", int'(ovalid), int'(m_ov));
    chk("ofield", int'(ofield), int'(m_of));
    chk("err", int'(err), int'(m_err));
    chk("cnt", int'(dbg_cnt), m_bq.size());
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] w;
    logic       iv, fl;
    logic [3:0] rl;
    logic       rv, orr, pre;
    logic       e_ir, e_rr;
    logic [7:0] e_of;
    logic       e_ov;
    logic [4:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [7:0] w, input logic iv,
                     input logic fl, input logic [3:0] rl, input logic rv,
                     input logic orr, input logic pre, input logic e_ir,
                     input logic e_rr, input logic [7:0] e_of, input logic e_ov,
                     input logic [4:0] e_cnt, input logic e_err);
    vec_t v;
    v = '{rst, w, iv, fl, rl, rv, orr, pre, e_ir, e_rr, e_of, e_ov, e_cnt, e_err};
    tbl.push_back(v);
  endtask

  initial begin
    vec_t       v;
    logic       ir, rr;
    logic [3:0] rl;
    reset_n = 1'b0; iword = 8'h00; ivalid = 1'b0; iflush = 1'b0;
    rlen = 4'd0; rvalid = 1'b0; oready = 1'b1;
    @(negedge clock);

    //   rst  w     iv fl rl rv orr pre ir rr  of    ov cnt err
    // reset and basic extraction
    add(1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0,  0);
    add(0, 8'hA5, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 8,  0);
    add(0, 8'h00, 0, 0, 3, 1, 1, 1, 1, 1, 8'h05, 1, 5,  0);
    add(0, 8'h00, 0, 0, 5, 1, 1, 1, 1, 1, 8'h14, 1, 0,  0);
    add(0, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h14, 0, 0,  0);
    add(0, 8'h00, 0, 0, 8, 1, 1, 1, 1, 0, 8'h14, 0, 0,  0);
    // word-spanning field
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0,  0);
    add(0, 8'hFF, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 8,  0);
    add(0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 16, 0);
    add(0, 8'h00, 0, 0, 4, 1, 1, 1, 0, 1, 8'h0F, 1, 12, 0);
    add(0, 8'h00, 0, 0, 8, 1, 1, 1, 0, 1, 8'h0F, 1, 4,  0);
    add(0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 1, 8'h0F, 0, 4,  0);
    // simultaneous push and pop, then backpressure
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0,  0);
    add(0, 8'hA5, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 8,  0);
    add(0, 8'h3C, 1, 0, 3, 1, 1, 1, 1, 1, 8'h05, 1, 13, 0);
    add(0, 8'h00, 0, 0, 8, 1, 1, 1, 0, 1, 8'h94, 1, 5,  0);
    add(0, 8'h00, 0, 0, 2, 1, 0, 1, 1, 0, 8'h94, 1, 5,  0);
    add(0, 8'h00, 0, 0, 2, 1, 0, 1, 1, 0, 8'h94, 1, 5,  0);
    add(0, 8'h00, 0, 0, 2, 1, 0, 1, 1, 0, 8'h94, 1, 5,  0);
    add(0, 8'h00, 0, 0, 2, 1, 1, 1, 1, 1, 8'h03, 1, 3,  0);
    add(0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 1, 8'h03, 0, 3,  0);
    // full buffer and illegal length
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0,  0);
    add(0, 8'h12, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 8,  0);
    add(0, 8'h34, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 16, 0);
    add(0, 8'h56, 1, 0, 0, 0, 1, 1, 0, 1, 8'h00, 0, 16, 0);
    add(0, 8'h00, 0, 0, 9, 1, 1, 1, 0, 0, 8'h00, 0, 16, 1);
    add(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 1, 8'h00, 0, 16, 1);
    add(0, 8'h00, 0, 0, 8, 1, 1, 1, 0, 1, 8'h12, 1, 8,  1);
    add(1, 8'h77, 1, 0, 3, 1, 1, 0, 0, 0, 8'h00, 0, 0,  0);
    // flush with a pending output, then reset while ovalid is high
    add(0, 8'hFF, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 8,  0);
    add(0, 8'hFF, 1, 0, 0, 0, 1, 1, 1, 1, 8'h00, 0, 16, 0);
    add(0, 8'h00, 0, 0, 5, 1, 0, 1, 0, 1, 8'h1F, 1, 11, 0);
    add(0, 8'hAA, 1, 1, 3, 1, 0, 1, 0, 0, 8'h1F, 1, 0,  0);
    add(1, 8'h00, 1, 0, 3, 1, 0, 0, 0, 0, 8'h00, 0, 0,  0);
    add(0, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h00, 0, 0,  0);

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      step(v.rst, v.w, v.iv, v.fl, v.rl, v.rv, v.orr, v.pre, ir, rr);
      if (v.pre) begin
        chk($sformatf("tbl%0d_iready", r), int'(ir), int'(v.e_ir));
        chk($sformatf("tbl%0d_rready", r), int'(rr), int'(v.e_rr));
      end
      chk($sformatf("tbl%0d_ofield", r), int'(ofield), int'(v.e_of));
      chk($sformatf("tbl%0d_ovalid", r), int'(ovalid), int'(v.e_ov));
      chk($sformatf("tbl%0d_cnt", r), int'(dbg_cnt), int'(v.e_cnt));
      chk($sformatf("tbl%0d_err", r), int'(err), int'(v.e_err));
    end

    // randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      logic do_rst;
      do_rst = ($urandom_range(0, 149) == 0);
      rl = ($urandom_range(0, 59) == 0) ? 4'd9 : 4'($urandom_range(0, 8));
      step(do_rst, 8'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
           rl, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7), !do_rst, ir, rr);
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
